// File: rtl/wbq_pkg.sv
// Shared types and constants for the register-file writeback queue.
// Optional coalescing of same-register writes is enabled with WBQ_COALESCE_EN.
package wbq_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 3'd0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] reg_num;
    logic [DATA_W-1:0]     data;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Finds the youngest pending write to one register. Purely combinational; no flow control.
module wbq_match
  import wbq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wbq_entry_t              entries [DEPTH],
  input  logic [PTR_W-1:0]        headPtr,
  input  logic [REG_ADDR_W-1:0]   lkNum,
  output logic                    lkHit,
  output logic [DATA_W-1:0]       lkData
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    lkHit  = 1'b0;
    lkData = '0;
    idx    = headPtr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = headPtr + PTR_W'(i);
      if (entries[idx].valid && (entries[idx].reg_num == lkNum) && (lkNum != REG_ZERO)) begin
        lkHit  = 1'b1;
        lkData = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// Buffers register writes and retires one per cycle into the register file; retire is 1 cycle after accept.
// Backpressure: in_ready drops when full (WBQ_COALESCE_EN lets a same-register write merge into the youngest entry).
module reg_writeback_queue
  import wbq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  drain_en,
  output logic                  rf_regWrite,
  output logic [REG_ADDR_W-1:0] rf_regWriteNum,
  output logic [DATA_W-1:0]     rf_writeData,
  input  logic [REG_ADDR_W-1:0] lk_num1,
  input  logic [REG_ADDR_W-1:0] lk_num2,
  output logic                  lk_hit1,
  output logic                  lk_hit2,
  output logic [DATA_W-1:0]     lk_data1,
  output logic [DATA_W-1:0]     lk_data2,
  output logic [CNT_W-1:0]      pending_cnt
);

  wbq_entry_t       entries [DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [CNT_W-1:0] cnt;

  logic isEmpty;
  logic isFull;
  logic isZero;
  logic accept;
  logic doDrain;
  logic doPush;
  logic doCoalesce;

  assign isEmpty = (cnt == '0);
  assign isFull  = (cnt == CNT_W'(DEPTH));
  assign isZero  = (in_reg == REG_ZERO);

  // Nothing retires while reset is held, so pending writes are truly discarded.
  assign doDrain = drain_en && !isEmpty && !reset;

`ifdef WBQ_COALESCE_EN
  logic [PTR_W-1:0] youngIdx;
  logic             canCoalesce;

  assign youngIdx    = tailPtr - PTR_W'(1);
  // A lone entry leaving this cycle cannot absorb the request.
  assign canCoalesce = !isEmpty && !isZero && (entries[youngIdx].reg_num == in_reg)
                       && !(doDrain && (cnt == CNT_W'(1)));
  assign in_ready    = !isFull || canCoalesce;
  assign doCoalesce  = accept && canCoalesce;
`else
  assign in_ready    = !isFull;
  assign doCoalesce  = 1'b0;
`endif

  assign accept = in_valid && in_ready;
  assign doPush = accept && !isZero && !doCoalesce;

  assign rf_regWrite    = doDrain;
  assign rf_regWriteNum = isEmpty ? '0 : entries[headPtr].reg_num;
  assign rf_writeData   = isEmpty ? '0 : entries[headPtr].data;
  assign pending_cnt    = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      cnt     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (doPush) begin
        entries[tailPtr] <= '{valid: 1'b1, reg_num: in_reg, data: in_data};
        tailPtr          <= tailPtr + PTR_W'(1);
      end
`ifdef WBQ_COALESCE_EN
      if (doCoalesce) begin
        entries[youngIdx].data <= in_data;
      end
`endif
      if (doDrain) begin
        entries[headPtr].valid <= 1'b0;
        headPtr                <= headPtr + PTR_W'(1);
      end
      cnt <= cnt + CNT_W'(doPush) - CNT_W'(doDrain);
    end
  end

  wbq_match #(.DEPTH(DEPTH)) u_match1 (
    .entries (entries),
    .headPtr (headPtr),
    .lkNum   (lk_num1),
    .lkHit   (lk_hit1),
    .lkData  (lk_data1)
  );

  wbq_match #(.DEPTH(DEPTH)) u_match2 (
    .entries (entries),
    .headPtr (headPtr),
    .lkNum   (lk_num2),
    .lkHit   (lk_hit2),
    .lkData  (lk_data2)
  );

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: vector table, directed corner sequences, random vs queue model.
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_reg;
  logic [15:0] in_data;
  logic        drain_en;
  logic        rf_regWrite;
  logic [2:0]  rf_regWriteNum;
  logic [15:0] rf_writeData;
  logic [2:0]  lk_num1;
  logic [2:0]  lk_num2;
  logic        lk_hit1;
  logic        lk_hit2;
  logic [15:0] lk_data1;
  logic [15:0] lk_data2;
  logic [2:0]  pending_cnt;

  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_reg         (in_reg),
    .in_data        (in_data),
    .drain_en       (drain_en),
    .rf_regWrite    (rf_regWrite),
    .rf_regWriteNum (rf_regWriteNum),
    .rf_writeData   (rf_writeData),
    .lk_num1        (lk_num1),
    .lk_num2        (lk_num2),
    .lk_hit1        (lk_hit1),
    .lk_hit2        (lk_hit2),
    .lk_data1       (lk_data1),
    .lk_data2       (lk_data2),
    .pending_cnt    (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pending writes as an ordered list, oldest first.
  typedef struct packed {
    logic [2:0]  r;
    logic [15:0] d;
  } ment_t;
  ment_t mq[$];

  logic        lastRdy;
  logic        lastWr;
  logic [15:0] lastDat;

  function automatic void look(input logic [2:0] n, output logic h, output logic [15:0] dd);
    h  = 1'b0;
    dd = 16'd0;
    if (n != 3'd0) begin
      foreach (mq[i]) begin
        if (mq[i].r == n) begin
          h  = 1'b1;
          dd = mq[i].d;
        end
      end
    end
  endfunction

  task automatic mcyc(input logic v, input logic [2:0] r, input logic [15:0] d,
                      input logic dr, input logic [2:0] l1, input logic [2:0] l2);
    int          sz;
    logic        empty;
    logic        drn;
    logic        match;
    logic        rdy;
    logic        h;
    logic [15:0] hd;
    ment_t       tmp;
    @(negedge clk);
    in_valid = v; in_reg = r; in_data = d; drain_en = dr; lk_num1 = l1; lk_num2 = l2;
    #2;
    sz    = mq.size();
    empty = (sz == 0);
    drn   = dr && !empty;
    match = 1'b0;
`ifdef WBQ_COALESCE_EN
    if (!empty && (r != 3'd0) && (mq[sz-1].r == r) && !(drn && sz == 1)) match = 1'b1;
`endif
    rdy = (sz < DEPTH) || match;
    chk("m.in_ready", {31'd0, in_ready}, {31'd0, rdy});
    chk("m.rf_regWrite", {31'd0, rf_regWrite}, {31'd0, drn});
    chk("m.rf_regWriteNum", {29'd0, rf_regWriteNum}, empty ? 32'd0 : {29'd0, mq[0].r});
    chk("m.rf_writeData", {16'd0, rf_writeData}, empty ? 32'd0 : {16'd0, mq[0].d});
    chk("m.pending_cnt", {29'd0, pending_cnt}, sz);
    look(l1, h, hd);
    chk("m.lk_hit1", {31'd0, lk_hit1}, {31'd0, h});
    chk("m.lk_data1", {16'd0, lk_data1}, {16'd0, hd});
    look(l2, h, hd);
    chk("m.lk_hit2", {31'd0, lk_hit2}, {31'd0, h});
    chk("m.lk_data2", {16'd0, lk_data2}, {16'd0, hd});
    lastRdy = in_ready;
    lastWr  = rf_regWrite;
    lastDat = rf_writeData;
    if (v && rdy && (r != 3'd0)) begin
      if (match) begin
        tmp = mq.pop_back();
        tmp.d = d;
        mq.push_back(tmp);
      end else begin
        tmp.r = r;
        tmp.d = d;
        mq.push_back(tmp);
      end
    end
    if (drn) void'(mq.pop_front());
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; drain_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  r;
    logic [15:0] d;
    logic        dr;
    logic [2:0]  l1;
    logic [2:0]  l2;
    logic        eWr;
    logic [2:0]  eNum;
    logic [15:0] eDat;
    logic        eH1;
    logic [15:0] eD1;
    logic        eH2;
    logic [15:0] eD2;
    logic [2:0]  eCnt;
    logic        eRdy;
  } vec_t;
  vec_t vecs[$];

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_reg = 3'd0; in_data = 16'd0;
    drain_en = 1'b0; lk_num1 = 3'd0; lk_num2 = 3'd0;
    lastRdy = 1'b0; lastWr = 1'b0; lastDat = 16'd0;

    // reg4=20 with drain, r0 write, then fill/hold/drain of four writes
    vecs.push_back('{1, 4, 20, 1, 4, 0, 0, 0, 0,  0, 0,  0, 0, 0, 1});
    vecs.push_back('{0, 0, 0,  1, 4, 0, 1, 4, 20, 1, 20, 0, 0, 1, 1});
    vecs.push_back('{0, 0, 0,  1, 4, 0, 0, 0, 0,  0, 0,  0, 0, 0, 1});
    vecs.push_back('{1, 0, 16'hFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0, 0,  1, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 1});
    vecs.push_back('{1, 1, 5,  0, 1, 2, 0, 0, 0,  0, 0,  0, 0, 0, 1});
    vecs.push_back('{1, 2, 6,  0, 1, 2, 0, 1, 5,  1, 5,  0, 0, 1, 1});
    vecs.push_back('{1, 3, 7,  0, 1, 2, 0, 1, 5,  1, 5,  1, 6, 2, 1});
    vecs.push_back('{1, 1, 9,  0, 1, 2, 0, 1, 5,  1, 5,  1, 6, 3, 1});
    vecs.push_back('{1, 5, 16'h55, 0, 1, 2, 0, 1, 5, 1, 9, 1, 6, 4, 0});
    vecs.push_back('{0, 0, 0,  1, 1, 2, 1, 1, 5,  1, 9,  1, 6, 4, 0});
    vecs.push_back('{0, 0, 0,  1, 1, 2, 1, 2, 6,  1, 9,  1, 6, 3, 1});
    vecs.push_back('{0, 0, 0,  1, 1, 2, 1, 3, 7,  1, 9,  0, 0, 2, 1});
    vecs.push_back('{0, 0, 0,  1, 1, 2, 1, 1, 9,  1, 9,  0, 0, 1, 1});
    vecs.push_back('{0, 0, 0,  1, 1, 2, 0, 0, 0,  0, 0,  0, 0, 0, 1});

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst.pending_cnt", {29'd0, pending_cnt}, 32'd0);
    chk("rst.rf_regWrite", {31'd0, rf_regWrite}, 32'd0);
    chk("rst.rf_regWriteNum", {29'd0, rf_regWriteNum}, 32'd0);
    chk("rst.rf_writeData", {16'd0, rf_writeData}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.lk_hit1", {31'd0, lk_hit1}, 32'd0);
    chk("rst.lk_data2", {16'd0, lk_data2}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_valid = vecs[i].v; in_reg = vecs[i].r; in_data = vecs[i].d;
      drain_en = vecs[i].dr; lk_num1 = vecs[i].l1; lk_num2 = vecs[i].l2;
      #2;
      chk($sformatf("vec%0d.rf_regWrite", i), {31'd0, rf_regWrite}, {31'd0, vecs[i].eWr});
      chk($sformatf("vec%0d.rf_regWriteNum", i), {29'd0, rf_regWriteNum}, {29'd0, vecs[i].eNum});
      chk($sformatf("vec%0d.rf_writeData", i), {16'd0, rf_writeData}, {16'd0, vecs[i].eDat});
      chk($sformatf("vec%0d.lk_hit1", i), {31'd0, lk_hit1}, {31'd0, vecs[i].eH1});
      chk($sformatf("vec%0d.lk_data1", i), {16'd0, lk_data1}, {16'd0, vecs[i].eD1});
      chk($sformatf("vec%0d.lk_hit2", i), {31'd0, lk_hit2}, {31'd0, vecs[i].eH2});
      chk($sformatf("vec%0d.lk_data2", i), {16'd0, lk_data2}, {16'd0, vecs[i].eD2});
      chk($sformatf("vec%0d.pending_cnt", i), {29'd0, pending_cnt}, {29'd0, vecs[i].eCnt});
      chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].eRdy});
    end

    // Full queue with drain: request held this cycle, accepted next at count 3
    doReset();
    mcyc(1, 3'd1, 16'h11, 0, 1, 4);
    mcyc(1, 3'd2, 16'h22, 0, 1, 4);
    mcyc(1, 3'd3, 16'h33, 0, 1, 4);
    mcyc(1, 3'd4, 16'h44, 0, 1, 4);
    mcyc(1, 3'd6, 16'h66, 1, 6, 4);
    chk("fullDrain.in_ready", {31'd0, lastRdy}, 32'd0);
    chk("fullDrain.rf_regWrite", {31'd0, lastWr}, 32'd1);
    mcyc(1, 3'd6, 16'h66, 1, 6, 4);
    chk("fullDrain.acceptNext", {31'd0, lastRdy}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      mcyc(1'($urandom_range(0, 1)), 3'($urandom_range(1, 7)), 16'($urandom),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    // Reset with three pending writes: none may retire
    doReset();
    mcyc(1, 3'd2, 16'hA1, 0, 2, 3);
    mcyc(1, 3'd3, 16'hA2, 0, 2, 3);
    mcyc(1, 3'd5, 16'hA3, 0, 2, 3);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; drain_en = 1'b1;
    #2;
    chk("midReset.rf_regWrite", {31'd0, rf_regWrite}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    #2;
    chk("postReset.pending_cnt", {29'd0, pending_cnt}, 32'd0);
    chk("postReset.rf_regWrite", {31'd0, rf_regWrite}, 32'd0);
    chk("postReset.lk_hit1", {31'd0, lk_hit1}, 32'd0);
    chk("postReset.lk_hit2", {31'd0, lk_hit2}, 32'd0);
    repeat (3) mcyc(0, 3'd0, 16'd0, 1, 2, 5);

    // Back-to-back writes to the same register
    doReset();
    mcyc(1, 3'd5, 16'd1, 0, 5, 0);
    mcyc(1, 3'd5, 16'd2, 0, 5, 0);
    mcyc(0, 3'd0, 16'd0, 0, 5, 0);
    chk("same.lk_data1", {16'd0, lk_data1}, 32'd2);
`ifdef WBQ_COALESCE_EN
    chk("same.pending_cnt", {29'd0, pending_cnt}, 32'd1);
`else
    chk("same.pending_cnt", {29'd0, pending_cnt}, 32'd2);
`endif
    mcyc(0, 3'd0, 16'd0, 1, 5, 0);
`ifdef WBQ_COALESCE_EN
    chk("same.firstRetire", {16'd0, lastDat}, 32'd2);
`else
    chk("same.firstRetire", {16'd0, lastDat}, 32'd1);
`endif
    repeat (2) mcyc(0, 3'd0, 16'd0, 1, 5, 0);

    // Random traffic against the model
    doReset();
    for (int i = 0; i < 400; i++) begin
      mcyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
           1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
